// File: rtl/alu_system_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_system_sequencer
// Function : Multi-cycle control unit for the ALU datapath system. Fetches a
//            16-bit instruction as two byte reads at PC, executes it in one
//            cycle, and counts retired instructions. Supports run/halt.
// Revision : 1.0 - initial release
// ============================================================================
module alu_system_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Run,
   input  logic [15:0]      IROut,
   input  logic [3:0]       Flags,
   output logic [2:0]       RF_OutASel,
   output logic [2:0]       RF_OutBSel,
   output logic [2:0]       RF_FunSel,
   output logic [3:0]       RF_RegSel,
   output logic [3:0]       RF_ScrSel,
   output logic [4:0]       ALU_FunSel,
   output logic             ALU_WF,
   output logic [2:0]       ARF_RegSel,
   output logic [1:0]       ARF_FunSel,
   output logic [1:0]       ARF_OutCSel,
   output logic [1:0]       ARF_OutDSel,
   output logic [1:0]       MuxASel,
   output logic [1:0]       MuxBSel,
   output logic [1:0]       MuxCSel,
   output logic             MuxDSel,
   output logic [1:0]       DR_FunSel,
   output logic             DR_E,
   output logic             IR_Write,
   output logic             IR_LH,
   output logic             Mem_WR,
   output logic             Mem_CS,
   output logic             Halted,
   output logic             Illegal,
   output logic [CNT_W-1:0] InstrCount
);

   localparam logic [2:0] c_S_IDLE    = 3'd0;
   localparam logic [2:0] c_S_FETCH_L = 3'd1;
   localparam logic [2:0] c_S_FETCH_H = 3'd2;
   localparam logic [2:0] c_S_EXEC    = 3'd3;
   localparam logic [2:0] c_S_HALT    = 3'd4;

   localparam logic [3:0] c_OP_NOP = 4'h0;
   localparam logic [3:0] c_OP_ADD = 4'h1;
   localparam logic [3:0] c_OP_SUB = 4'h2;
   localparam logic [3:0] c_OP_AND = 4'h3;
   localparam logic [3:0] c_OP_ORR = 4'h4;
   localparam logic [3:0] c_OP_LDI = 4'h5;
   localparam logic [3:0] c_OP_BRA = 4'h6;
   localparam logic [3:0] c_OP_BEQ = 4'h7;
   localparam logic [3:0] c_OP_HLT = 4'hF;

   localparam logic [2:0] c_RF_HOLD  = 3'b000;
   localparam logic [2:0] c_RF_LOAD  = 3'b010;
   localparam logic [1:0] c_ARF_INC  = 2'b01;
   localparam logic [1:0] c_ARF_LOAD = 2'b10;
   localparam logic [4:0] c_ALU_ADD  = 5'b10100;
   localparam logic [4:0] c_ALU_SUB  = 5'b10110;
   localparam logic [4:0] c_ALU_AND  = 5'b10111;
   localparam logic [4:0] c_ALU_ORR  = 5'b11000;

   logic [2:0]       r_state;
   logic [2:0]       w_next_state;
   logic [CNT_W-1:0] r_count;

   // Instruction fields; IMM is consumed directly by the datapath from IR
   logic [3:0] w_opc;
   logic [1:0] w_dst;
   logic [1:0] w_src1;
   logic [1:0] w_src2;
   logic [3:0] w_dst_onehot;
   logic       w_zero;
   logic       w_unused;

   assign w_opc        = IROut[15:12];
   assign w_dst        = IROut[11:10];
   assign w_src1       = IROut[9:8];
   assign w_src2       = IROut[7:6];
   assign w_dst_onehot = 4'b0001 << w_dst;
   assign w_zero       = Flags[3];
   assign w_unused     = ^{Flags[2:0], IROut[5:0]};

   // State register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) r_state <= c_S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state decode; Run only matters in IDLE and when leaving EXEC
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_S_IDLE:    if (Run) w_next_state = c_S_FETCH_L;
         c_S_FETCH_L: w_next_state = c_S_FETCH_H;
         c_S_FETCH_H: w_next_state = c_S_EXEC;
         c_S_EXEC: begin
            if (w_opc == c_OP_HLT) w_next_state = c_S_HALT;
            else if (Run)          w_next_state = c_S_FETCH_L;
            else                   w_next_state = c_S_IDLE;
         end
         c_S_HALT:    w_next_state = c_S_HALT;
         default:     w_next_state = c_S_IDLE;
      endcase
   end

   // Retired-instruction counter: every EXEC cycle retires exactly one instruction
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)                  r_count <= '0;
      else if (r_state == c_S_EXEC) r_count <= r_count + CNT_W'(1);
   end

   assign InstrCount = r_count;

   // Moore output decode from state, with the opcode selecting EXEC controls
   always_comb begin
      RF_OutASel  = 3'b000;
      RF_OutBSel  = 3'b000;
      RF_FunSel   = c_RF_HOLD;
      RF_RegSel   = 4'b0000;
      RF_ScrSel   = 4'b0000;
      ALU_FunSel  = 5'b00000;
      ALU_WF      = 1'b0;
      ARF_RegSel  = 3'b000;
      ARF_FunSel  = 2'b00;
      ARF_OutCSel = 2'b00;
      ARF_OutDSel = 2'b00;
      MuxASel     = 2'b00;
      MuxBSel     = 2'b00;
      MuxCSel     = 2'b00;
      MuxDSel     = 1'b0;
      DR_FunSel   = 2'b00;
      DR_E        = 1'b0;
      IR_Write    = 1'b0;
      IR_LH       = 1'b0;
      Mem_WR      = 1'b0;
      Mem_CS      = 1'b1;
      Halted      = (r_state == c_S_HALT);
      Illegal     = 1'b0;
      case (r_state)
         c_S_FETCH_L, c_S_FETCH_H: begin
            // Read the byte at PC into IR and post-increment PC
            Mem_CS      = 1'b0;
            ARF_OutDSel = 2'b00;
            IR_Write    = 1'b1;
            IR_LH       = (r_state == c_S_FETCH_H);
            ARF_RegSel  = 3'b100;
            ARF_FunSel  = c_ARF_INC;
         end
         c_S_EXEC: begin
            case (w_opc)
               c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_ORR: begin
                  RF_OutASel = {1'b0, w_src1};
                  RF_OutBSel = {1'b0, w_src2};
                  MuxDSel    = 1'b0;
                  ALU_WF     = 1'b1;
                  MuxASel    = 2'b00;
                  RF_RegSel  = w_dst_onehot;
                  RF_FunSel  = c_RF_LOAD;
                  case (w_opc)
                     c_OP_ADD: ALU_FunSel = c_ALU_ADD;
                     c_OP_SUB: ALU_FunSel = c_ALU_SUB;
                     c_OP_AND: ALU_FunSel = c_ALU_AND;
                     default:  ALU_FunSel = c_ALU_ORR;
                  endcase
               end
               c_OP_LDI: begin
                  MuxASel   = 2'b11;
                  RF_RegSel = w_dst_onehot;
                  RF_FunSel = c_RF_LOAD;
               end
               c_OP_BRA, c_OP_BEQ: begin
                  // Loading PC here overrides the two fetch increments
                  if (w_opc == c_OP_BRA || w_zero) begin
                     MuxBSel    = 2'b11;
                     ARF_RegSel = 3'b100;
                     ARF_FunSel = c_ARF_LOAD;
                  end
               end
               c_OP_NOP, c_OP_HLT: ;
               default: Illegal = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_system_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_system_sequencer
// Function : Scoreboard bench for alu_system_sequencer. A driver issues
//            instructions and queues the expected EXEC controls; a monitor
//            walks the fetch/exec sequence and compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_system_sequencer;

   // Narrow counter so the wrap-around is reached in a few hundred instructions
   localparam int CW = 8;

   typedef struct packed {
      logic [2:0] oa;
      logic [2:0] ob;
      logic [2:0] rf_fun;
      logic [3:0] rs;
      logic [3:0] ss;
      logic [4:0] alu_fun;
      logic       wf;
      logic [2:0] arf_rs;
      logic [1:0] arf_fun;
      logic [1:0] oc;
      logic [1:0] od;
      logic [1:0] ma;
      logic [1:0] mb;
      logic [1:0] mc;
      logic [1:0] dr_fun;
      logic       md;
      logic       dre;
      logic       irw;
      logic       irlh;
      logic       mwr;
      logic       mcs;
      logic       halted;
      logic       illegal;
   } ctl_t;

   typedef struct {
      ctl_t            exp;
      logic [CW-1:0]   cnt;
      bit              halt;
   } item_t;

   logic          Clock;
   logic          Reset;
   logic          Run;
   logic [15:0]   IROut;
   logic [3:0]    Flags;
   logic [2:0]    RF_OutASel, RF_OutBSel, RF_FunSel;
   logic [3:0]    RF_RegSel, RF_ScrSel;
   logic [4:0]    ALU_FunSel;
   logic          ALU_WF;
   logic [2:0]    ARF_RegSel;
   logic [1:0]    ARF_FunSel, ARF_OutCSel, ARF_OutDSel;
   logic [1:0]    MuxASel, MuxBSel, MuxCSel, DR_FunSel;
   logic          MuxDSel, DR_E, IR_Write, IR_LH, Mem_WR, Mem_CS, Halted, Illegal;
   logic [CW-1:0] InstrCount;

   alu_system_sequencer #(.CNT_W(CW)) dut (
      .Clock(Clock), .Reset(Reset), .Run(Run), .IROut(IROut), .Flags(Flags),
      .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
      .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
      .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
      .ARF_RegSel(ARF_RegSel), .ARF_FunSel(ARF_FunSel),
      .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
      .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .MuxDSel(MuxDSel),
      .DR_FunSel(DR_FunSel), .DR_E(DR_E),
      .IR_Write(IR_Write), .IR_LH(IR_LH), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
      .Halted(Halted), .Illegal(Illegal), .InstrCount(InstrCount)
   );

   ctl_t act;
   assign act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
                 ALU_FunSel, ALU_WF, ARF_RegSel, ARF_FunSel, ARF_OutCSel,
                 ARF_OutDSel, MuxASel, MuxBSel, MuxCSel, DR_FunSel, MuxDSel,
                 DR_E, IR_Write, IR_LH, Mem_WR, Mem_CS, Halted, Illegal};

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int            n_chk  = 0;
   int            n_fail = 0;
   item_t         sb[$];
   logic [CW-1:0] m_cnt;

   // ---------------- reference model ----------------
   function automatic ctl_t idle_v();
      ctl_t e;
      e     = '0;
      e.mcs = 1'b1;
      return e;
   endfunction

   function automatic ctl_t halt_v();
      ctl_t e;
      e        = idle_v();
      e.halted = 1'b1;
      return e;
   endfunction

   function automatic ctl_t fetch_v(input bit hi);
      ctl_t e;
      e         = idle_v();
      e.mcs     = 1'b0;
      e.irw     = 1'b1;
      e.irlh    = hi;
      e.arf_rs  = 3'b100;
      e.arf_fun = 2'b01;
      e.od      = 2'b00;
      return e;
   endfunction

   function automatic ctl_t exp_exec(input logic [15:0] ins, input logic z);
      ctl_t       e;
      logic [3:0] op;
      int         dst;
      op  = ins[15:12];
      dst = int'(ins[11:10]);
      e   = idle_v();
      if (op >= 4'd1 && op <= 4'd4) begin
         e.oa      = {1'b0, ins[9:8]};
         e.ob      = {1'b0, ins[7:6]};
         e.alu_fun = (op == 4'd1) ? 5'b10100 : (op == 4'd2) ? 5'b10110 :
                     (op == 4'd3) ? 5'b10111 : 5'b11000;
         e.wf      = 1'b1;
         e.rs      = 4'(1 << dst);
         e.rf_fun  = 3'b010;
      end else if (op == 4'd5) begin
         e.ma     = 2'b11;
         e.rs     = 4'(1 << dst);
         e.rf_fun = 3'b010;
      end else if (op == 4'd6 || (op == 4'd7 && z)) begin
         e.mb      = 2'b11;
         e.arf_rs  = 3'b100;
         e.arf_fun = 2'b10;
      end else if (op >= 4'd8 && op <= 4'd14) begin
         e.illegal = 1'b1;
      end
      return e;
   endfunction

   // ---------------- comparison helpers ----------------
   task automatic chk_vec(input string nm, input ctl_t a, input ctl_t e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s at %0t: controls got %h expected %h", nm, $time, a, e);
      end
   endtask

   task automatic chk_cnt(input string nm, input logic [CW-1:0] a, input logic [CW-1:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s at %0t: InstrCount got %0d expected %0d", nm, $time, a, e);
      end
   endtask

   // ---------------- driver ----------------
   task automatic issue(input logic [15:0] ins, input logic z, input bit keep_run);
      int    w;
      item_t it;
      w   = 0;
      Run = 1'b1;
      do begin
         @(negedge Clock);
         w++;
      end while (!(!Mem_CS && IR_Write && !IR_LH) && w < 20);
      if (w >= 20) begin
         n_chk++;
         n_fail++;
         $display("FAIL issue_timeout at %0t: no FETCH_L within 20 cycles, got Mem_CS=%b expected 0", $time, Mem_CS);
      end
      IROut = ins;
      Flags = {z, 3'($urandom)};
      if (!keep_run) Run = 1'b0;
      m_cnt    = CW'((int'(m_cnt) + 1) % (1 << CW));
      it.exp   = exp_exec(ins, z);
      it.cnt   = m_cnt;
      it.halt  = (ins[15:12] == 4'hF);
      sb.push_back(it);
   endtask

   // ---------------- monitor ----------------
   int            mstate;
   bit            cnt_pend;
   bit            halted_m;
   logic [CW-1:0] pend_cnt;
   item_t         mit;

   initial begin
      mstate   = 0;
      cnt_pend = 0;
      halted_m = 0;
      pend_cnt = '0;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            mstate   = 0;
            cnt_pend = 0;
            halted_m = 0;
         end else begin
            if (cnt_pend) begin
               chk_cnt("retire_count", InstrCount, pend_cnt);
               cnt_pend = 0;
            end
            case (mstate)
               0: begin
                  if (halted_m) chk_vec("halt_state", act, halt_v());
                  else if (!Mem_CS) begin
                     chk_vec("fetch_l", act, fetch_v(1'b0));
                     mstate = 1;
                  end else chk_vec("idle_state", act, idle_v());
               end
               1: begin
                  chk_vec("fetch_h", act, fetch_v(1'b1));
                  mstate = 2;
               end
               default: begin
                  if (sb.size() == 0) begin
                     n_chk++;
                     n_fail++;
                     $display("FAIL unexpected_exec at %0t: got controls %h expected no instruction", $time, act);
                  end else begin
                     mit = sb.pop_front();
                     chk_vec("exec", act, mit.exp);
                     pend_cnt = mit.cnt;
                     cnt_pend = 1;
                     halted_m = mit.halt;
                  end
                  mstate = 0;
               end
            endcase
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      Reset = 1'b0;
      Run   = 1'b0;
      IROut = 16'h0000;
      Flags = 4'h0;
      m_cnt = '0;
      #1 Reset = 1'b1;
      #2;
      chk_vec("reset_idle", act, idle_v());
      chk_cnt("reset_count", InstrCount, '0);
      @(negedge Clock);
      @(negedge Clock);
      #2 Reset = 1'b0;

      // Directed instructions back to back
      issue(16'h1600, 1'b0, 1'b1);
      issue(16'h5C3A, 1'b0, 1'b1);
      issue(16'h7020, 1'b1, 1'b1);
      issue(16'h7020, 1'b0, 1'b1);
      issue(16'hA000, 1'b0, 1'b1);
      issue(16'h6055, 1'b0, 1'b1);

      // Random opcodes, excluding HLT
      for (int i = 0; i < 60; i++)
         issue({4'($urandom_range(0, 14)), 12'($urandom)}, 1'($urandom), 1'b1);

      // Run dropped during FETCH_L: instruction completes then FSM idles
      issue(16'h5C3A, 1'b1, 1'b0);
      repeat (6) @(negedge Clock);
      chk_vec("drop_idle", act, idle_v());

      // Asynchronous reset in the middle of FETCH_H
      issue(16'h1600, 1'b0, 1'b1);
      @(negedge Clock);
      #2 Reset = 1'b1;
      #1;
      chk_vec("reset_mid_fetch", act, idle_v());
      chk_cnt("reset_mid_count", InstrCount, '0);
      sb.delete();
      m_cnt = '0;
      Run   = 1'b0;
      @(negedge Clock);
      #2 Reset = 1'b0;
      repeat (5) @(negedge Clock);
      chk_vec("post_reset_idle", act, idle_v());

      // Counter wrap-around through NOPs
      while (m_cnt != {CW{1'b1}}) issue(16'h0000, 1'b0, 1'b1);
      issue(16'h0000, 1'b0, 1'b0);
      repeat (4) @(negedge Clock);
      chk_cnt("count_wrap", InstrCount, '0);

      // HLT: stays halted with Run held high
      issue(16'hF000, 1'b0, 1'b1);
      repeat (100) @(negedge Clock);
      chk_vec("halt_hold", act, halt_v());

      // Reset leaves HALT
      Run = 1'b0;
      #2 Reset = 1'b1;
      #1;
      chk_vec("reset_from_halt", act, idle_v());
      @(negedge Clock);
      #2 Reset = 1'b0;
      repeat (3) @(negedge Clock);

      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
